// File: rtl/spis_bridge_if.sv
// Valid/ready memory bus carried between the SPI bridge (master) and the
// register block or RAM behind it (slave).
interface spis_bridge_if #(
  parameter int AW = 12
);
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/spis_bridge.sv
// SPI mode-0 slave that turns write (0x02) and fast-read (0x0B) transactions
// into single-byte requests on the 32-bit valid/ready memory bus.
module spis_bridge #(
  parameter int AW    = 12,
  parameter int DUMMY = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_sck,
  input  logic          spi_cs_n,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic [1:0]    err,
  spis_bridge_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  localparam logic [4:0] DUMMY_CNT = 5'(DUMMY);

  state_t state_q, state_d;

  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_d, cs_d;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_fall;

  logic [4:0]    cnt_q;
  logic [14:0]   shift_q;
  logic [15:0]   addr_q;
  logic [7:0]    tx_q;
  logic [31:0]   rbuf_q;
  logic          rd_ok_q, rd_live_q, is_read_q;
  logic [1:0]    err_q;
  logic          mem_valid_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_wstrb_q;

  // All three SPI pins share the same 2-FF latency, so mosi lines up with sck.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop updates from pre-edge values.
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;

  logic [7:0]  rx_byte;
  logic [15:0] rx_addr;
  logic        cmd_done, addr_done, byte_in, dummy_end, rd_load, load;
  logic [15:0] load_addr;
  logic        byte_ok;
  logic [31:0] rd_word;

  assign rx_byte   = {shift_q[6:0], mosi_s};
  assign rx_addr   = {shift_q, mosi_s};
  assign cmd_done  = (state_q == S_CMD)   && sck_rise && (cnt_q == 5'd7);
  assign addr_done = (state_q == S_ADDR)  && sck_rise && (cnt_q == 5'd15);
  assign byte_in   = (state_q == S_WDATA) && sck_rise && (cnt_q == 5'd7);
  assign dummy_end = (state_q == S_DUMMY) && sck_fall && (cnt_q == DUMMY_CNT);
  assign rd_load   = (state_q == S_RDATA) && sck_fall && (cnt_q == 5'd8);
  assign load      = dummy_end || rd_load;
  assign load_addr = dummy_end ? addr_q : addr_q + 16'd1;

  // A fetch completing in the very cycle of a load is forwarded straight from the bus.
  assign byte_ok = rd_ok_q || (rd_live_q && mem_valid_q && mem.mem_ready);
  assign rd_word = rd_ok_q ? rbuf_q : mem.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    if (cs_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (cs_fall) state_d = S_CMD;
        S_CMD:   if (cmd_done)
                   state_d = (rx_byte == 8'h02 || rx_byte == 8'h0B) ? S_ADDR : S_IGNORE;
        S_ADDR:  if (addr_done) state_d = is_read_q ? S_DUMMY : S_WDATA;
        S_DUMMY: if (dummy_end) state_d = S_RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    spi_miso_oe = 1'b0;
    spi_miso    = 1'b0;
    if (state_q == S_RDATA) begin
      spi_miso_oe = 1'b1;
      spi_miso    = tx_q[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      rbuf_q      <= '0;
      rd_ok_q     <= 1'b0;
      rd_live_q   <= 1'b0;
      is_read_q   <= 1'b0;
      err_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      if (mem_valid_q && mem.mem_ready) begin
        mem_valid_q <= 1'b0;
        if (rd_live_q) begin
          rbuf_q    <= mem.mem_rdata;
          rd_ok_q   <= 1'b1;
          rd_live_q <= 1'b0;
        end
      end

      if (sck_rise) shift_q <= {shift_q[13:0], mosi_s};

      case (state_q)
        S_IDLE: begin
          // Late read data from an abandoned transaction must never reach MISO.
          cnt_q     <= '0;
          rd_ok_q   <= 1'b0;
          rd_live_q <= 1'b0;
          if (cs_fall) err_q <= '0;
        end
        S_CMD: if (sck_rise) begin
          cnt_q <= cmd_done ? 5'd0 : cnt_q + 5'd1;
          if (cmd_done) is_read_q <= (rx_byte == 8'h0B);
        end
        S_ADDR: if (sck_rise) begin
          cnt_q <= addr_done ? 5'd0 : cnt_q + 5'd1;
          if (addr_done) begin
            addr_q <= rx_addr;
            if (is_read_q) begin
              rd_ok_q <= 1'b0;
              if (!mem_valid_q) begin
                mem_valid_q <= 1'b1;
                mem_addr_q  <= AW'({rx_addr[15:2], 2'b00});
                mem_wstrb_q <= 4'b0000;
                rd_live_q   <= 1'b1;
              end else begin
                rd_live_q   <= 1'b0;
              end
            end
          end
        end
        S_DUMMY: if (sck_rise && cnt_q != DUMMY_CNT) cnt_q <= cnt_q + 5'd1;
        S_WDATA: if (sck_rise) begin
          cnt_q <= byte_in ? 5'd0 : cnt_q + 5'd1;
          if (byte_in) begin
            addr_q <= addr_q + 16'd1;
            if (mem_valid_q) begin
              err_q[0] <= 1'b1;
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= addr_q[AW-1:0];
              mem_wdata_q <= {4{rx_byte}};
              mem_wstrb_q <= 4'b0001 << addr_q[1:0];
            end
          end
        end
        S_RDATA: begin
          if (sck_fall && !rd_load) tx_q <= {tx_q[6:0], 1'b0};
          if (sck_rise) cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase

      if (load) begin
        cnt_q  <= '0;
        addr_q <= load_addr;
        if (byte_ok) begin
          tx_q <= rd_word[{load_addr[1:0], 3'b000} +: 8];
        end else begin
          tx_q     <= 8'hFF;
          err_q[1] <= 1'b1;
        end
        // Loading the last byte of a word prefetches the next word one byte ahead.
        if (load_addr[1:0] == 2'd3) begin
          rd_ok_q <= 1'b0;
          if (!mem_valid_q) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= AW'({load_addr[15:2] + 14'd1, 2'b00});
            mem_wstrb_q <= 4'b0000;
            rd_live_q   <= 1'b1;
          end else begin
            rd_live_q   <= 1'b0;
          end
        end
      end
    end
  end

  assign err           = err_q;
  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_spis_bridge.sv
// Directed bench for spis_bridge: an SPI master driver, a memory slave with an
// optional long stall, and a write log compared against hand-computed vectors.
module tb_spis_bridge;
  localparam int AW = 12;
  localparam int HP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sck = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe;
  logic [1:0] err;

  spis_bridge_if #(.AW(AW)) bus ();

  spis_bridge #(.AW(AW), .DUMMY(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .err(err), .mem(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } wr_t;

  wr_t wlog[$];
  int  valid_cycles = 0, oe_cycles = 0, miso_cycles = 0;
  int  req_cnt = 0;
  int  stall_at = -1;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    case (a)
      12'h000: return 32'h44332211;
      12'h004: return 32'h88776655;
      default: return 32'hC0DE0000 | 32'(a);
    endcase
  endfunction

  // Memory slave: 2-cycle latency, or 200 cycles for the request numbered stall_at.
  initial begin
    int lat;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid) begin
        lat = (req_cnt == stall_at) ? 200 : 2;
        req_cnt++;
        repeat (lat) @(posedge clk);
        #1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_valid) valid_cycles++;
    if (spi_miso_oe)   oe_cycles++;
    if (spi_miso)      miso_cycles++;
    if (bus.mem_valid && bus.mem_ready && bus.mem_wstrb != 4'b0000)
      wlog.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [AW-1:0] ea,
                           input logic [31:0] ed, input logic [3:0] es);
    if (idx < wlog.size()) begin
      check({name, " addr"},  32'(wlog[idx].addr), 32'(ea));
      check({name, " wdata"}, wlog[idx].wdata, ed);
      check({name, " wstrb"}, 32'(wlog[idx].wstrb), 32'(es));
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no bus write, required one at 0x%0h", name, ea);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the top nbits of tx MSB first; MISO is sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      tick(HP);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      tick(HP);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    tick(HP);
  endtask

  task automatic cs_end();
    tick(HP);
    spi_cs_n = 1'b1;
    tick(4 * HP);
  endtask

  typedef struct {
    logic          start;
    logic [15:0]   addr;
    logic [7:0]    data;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_strb;
    logic [31:0]   exp_wdata;
  } wvec_t;

  wvec_t wtab[6];

  initial begin
    logic [7:0] rx;
    logic [7:0] rd_exp[4];
    int base, snap_v, snap_oe, snap_miso;
    bit open;

    wtab[0] = '{1'b1, 16'h0010, 8'hA1, 12'h010, 4'b0001, 32'hA1A1A1A1};
    wtab[1] = '{1'b0, 16'h0000, 8'hB2, 12'h011, 4'b0010, 32'hB2B2B2B2};
    wtab[2] = '{1'b0, 16'h0000, 8'hC3, 12'h012, 4'b0100, 32'hC3C3C3C3};
    wtab[3] = '{1'b0, 16'h0000, 8'hD4, 12'h013, 4'b1000, 32'hD4D4D4D4};
    wtab[4] = '{1'b1, 16'hFFFF, 8'h77, 12'hFFF, 4'b1000, 32'h77777777};
    wtab[5] = '{1'b0, 16'h0000, 8'h88, 12'h000, 4'b0001, 32'h88888888};
    rd_exp  = '{8'h33, 8'h44, 8'h55, 8'h66};

    // Reset state
    tick(4);
    check("rst miso", 32'(spi_miso), 0);
    check("rst miso_oe", 32'(spi_miso_oe), 0);
    check("rst mem_valid", 32'(bus.mem_valid), 0);
    check("rst mem_addr", 32'(bus.mem_addr), 0);
    check("rst mem_wdata", bus.mem_wdata, 0);
    check("rst mem_wstrb", 32'(bus.mem_wstrb), 0);
    check("rst err", 32'(err), 0);
    rst_n = 1'b1;
    tick(4);

    // Table-driven write bursts: 4 bytes at 0x0010, then 2 bytes wrapping at 0xFFFF
    base = wlog.size();
    open = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (wtab[i].start) begin
        if (open) begin
          check("wr burst err", 32'(err), 0);
          cs_end();
        end
        cs_begin();
        spi_byte(8'h02, rx);
        spi_byte(wtab[i].addr[15:8], rx);
        spi_byte(wtab[i].addr[7:0], rx);
        open = 1'b1;
      end
      spi_byte(wtab[i].data, rx);
    end
    check("wr wrap err", 32'(err), 0);
    cs_end();
    check("wr count", 32'(wlog.size() - base), 6);
    for (int i = 0; i < 6; i++)
      check_log($sformatf("wr vec%0d", i), base + i,
                wtab[i].exp_addr, wtab[i].exp_wdata, wtab[i].exp_strb);

    // Read across a word boundary from 0x0002
    cs_begin();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h02, rx);
    spi_bits(8'h00, 7, rx);
    check("rd oe in dummy", 32'(spi_miso_oe), 0);
    spi_bits(8'h00, 1, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      check($sformatf("rd byte%0d", i), 32'(rx), 32'(rd_exp[i]));
      if (i == 0) check("rd oe in data", 32'(spi_miso_oe), 1);
    end
    check("rd err", 32'(err), 0);
    tick(HP);
    spi_cs_n = 1'b1;
    tick(3);
    check("rd oe after cs", 32'(spi_miso_oe), 0);
    tick(4 * HP);

    // Write with the first bus write stalled 200 clk: byte 2 dropped
    base = wlog.size();
    stall_at = req_cnt;
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h20, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    spi_byte(8'h33, rx);
    spi_byte(8'h44, rx);
    check("stall wr err", 32'(err), 1);
    cs_end();
    check("stall wr count", 32'(wlog.size() - base), 3);
    check_log("stall wr0", base,     12'h020, 32'h11111111, 4'b0001);
    check_log("stall wr1", base + 1, 12'h022, 32'h33333333, 4'b0100);
    check_log("stall wr2", base + 2, 12'h023, 32'h44444444, 4'b1000);

    // cs_n raised after 5 bits of a data byte, then a clean write
    base = wlog.size();
    cs_begin();
    spi_byte(8'h02, rx);
    check("abort err cleared", 32'(err), 0);
    spi_byte(8'h01, rx);
    spi_byte(8'h00, rx);
    spi_bits(8'hFF, 5, rx);
    cs_end();
    check("abort no write", 32'(wlog.size() - base), 0);
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h5A, rx);
    cs_end();
    check_log("after abort", base, 12'h101, 32'h5A5A5A5A, 4'b0010);

    // Unknown command 0x9F plus 3 bytes
    snap_v = valid_cycles;
    snap_oe = oe_cycles;
    snap_miso = miso_cycles;
    cs_begin();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, rx);
      check($sformatf("unk miso byte%0d", i), 32'(rx), 0);
    end
    cs_end();
    check("unk valid cycles", 32'(valid_cycles - snap_v), 0);
    check("unk oe cycles", 32'(oe_cycles - snap_oe), 0);
    check("unk miso cycles", 32'(miso_cycles - snap_miso), 0);

    // Read whose first fetch stalls past the dummy phase
    stall_at = req_cnt;
    cs_begin();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_bits(8'h00, 8, rx);
    spi_byte(8'h00, rx);
    check("stall rd byte", 32'(rx), 32'hFF);
    check("stall rd err", 32'(err), 2);
    cs_end();

    // Reset in the middle of a read with the prefetch of word 0x004 outstanding
    stall_at = req_cnt + 1;
    cs_begin();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h03, rx);
    spi_bits(8'h00, 8, rx);
    tick(6);
    check("pre-rst mem_valid", 32'(bus.mem_valid), 1);
    check("pre-rst mem_addr", 32'(bus.mem_addr), 32'h004);
    check("pre-rst oe", 32'(spi_miso_oe), 1);
    rst_n = 1'b0;
    #1;
    check("mid-rst miso", 32'(spi_miso), 0);
    check("mid-rst oe", 32'(spi_miso_oe), 0);
    check("mid-rst mem_valid", 32'(bus.mem_valid), 0);
    check("mid-rst mem_addr", 32'(bus.mem_addr), 0);
    check("mid-rst mem_wdata", bus.mem_wdata, 0);
    check("mid-rst mem_wstrb", 32'(bus.mem_wstrb), 0);
    check("mid-rst err", 32'(err), 0);
    spi_cs_n = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
